pc_unit: RTL and testbench



---
 rtl/pc_unit.sv | 72 +++++++
 tb/tb_pc_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter with exception/eret vectors, jump/branch redirects, and a
// pending-redirect slot that holds a redirect arriving during a stall.
module pc_unit #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180,
  parameter int              STEP      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             exc,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next_seq,
  output logic             fetch_valid,
  output logic             pc_misalign,
  output logic             redirect_pending
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic             pend_valid;
  logic [WIDTH-1:0] pend_target;
  logic             new_redir;
  logic [WIDTH-1:0] new_target;

  // jump outranks a simultaneous taken branch
  assign new_redir  = jump | br_taken;
  assign new_target = jump ? jump_target : br_target;

  assign pc_next_seq      = pc + STEP_W;
  assign pc_misalign      = |pc[1:0];
  assign redirect_pending = pend_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_VEC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= 1'b1;
      if (exc) begin
        pc         <= EXC_VEC;
        pend_valid <= 1'b0;
      end else if (eret) begin
        pc         <= epc;
        pend_valid <= 1'b0;
      end else if (new_redir) begin
        if (stall) begin
          pend_target <= new_target;
          pend_valid  <= 1'b1;
        end else begin
          pc         <= new_target;
          pend_valid <= 1'b0;
        end
      end else if (pend_valid && !stall) begin
        pc         <= pend_target;
        pend_valid <= 1'b0;
      end else if (!stall) begin
        pc <= pc_next_seq;
      end
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit using immediate assertions.
module tb_pc_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        exc;
  logic        eret;
  logic [31:0] epc;
  logic        jump;
  logic [31:0] jump_target;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] pc;
  logic [31:0] pc_next_seq;
  logic        fetch_valid;
  logic        pc_misalign;
  logic        redirect_pending;

  int checks;
  int errors;

  pc_unit dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .exc              (exc),
    .eret             (eret),
    .epc              (epc),
    .jump             (jump),
    .jump_target      (jump_target),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .pc               (pc),
    .pc_next_seq      (pc_next_seq),
    .fetch_valid      (fetch_valid),
    .pc_misalign      (pc_misalign),
    .redirect_pending (redirect_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // drive one cycle of inputs, then sample 1 time unit after the rising edge
  task automatic applyStimulus(input logic s, input logic e, input logic er,
                               input logic [31:0] ep, input logic j,
                               input logic [31:0] jt, input logic b,
                               input logic [31:0] bt);
    stall       = s;
    exc         = e;
    eret        = er;
    epc         = ep;
    jump        = j;
    jump_target = jt;
    br_taken    = b;
    br_target   = bt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    stall       = 1'b0;
    exc         = 1'b0;
    eret        = 1'b0;
    epc         = '0;
    jump        = 1'b0;
    jump_target = '0;
    br_taken    = 1'b0;
    br_target   = '0;

    // reset state while clock runs
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_pc", pc, 32'h3000);
    checkOutput("rst_fv", {31'b0, fetch_valid}, 32'h0);
    checkOutput("rst_rp", {31'b0, redirect_pending}, 32'h0);
    checkOutput("rst_nseq", pc_next_seq, 32'h3004);
    checkOutput("rst_mis", {31'b0, pc_misalign}, 32'h0);

    // release and run sequentially
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("seq1_pc", pc, 32'h3004);
    checkOutput("seq1_fv", {31'b0, fetch_valid}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("seq2_pc", pc, 32'h3008);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("seq3_pc", pc, 32'h300C);

    // branch during stall gets latched and applied on release
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'h3100);
    checkOutput("stbr_pc", pc, 32'h300C);
    checkOutput("stbr_rp", {31'b0, redirect_pending}, 32'h1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("sthold_pc", pc, 32'h300C);
    checkOutput("sthold_rp", {31'b0, redirect_pending}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("strel_pc", pc, 32'h3100);
    checkOutput("strel_rp", {31'b0, redirect_pending}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("postrel_pc", pc, 32'h3104);

    // latest pending redirect wins
    applyStimulus(1, 0, 0, 0, 1, 32'h3400, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'h3500);
    checkOutput("latest_hold", pc, 32'h3104);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("latest_pc", pc, 32'h3500);

    // exception beats jump and stall, and drops the pending redirect
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'h3600);
    checkOutput("pend_rp", {31'b0, redirect_pending}, 32'h1);
    applyStimulus(1, 1, 0, 0, 1, 32'h3800, 0, 0);
    checkOutput("exc_pc", pc, 32'h4180);
    checkOutput("exc_rp", {31'b0, redirect_pending}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("postexc_pc", pc, 32'h4184);

    // eret beats stall and a simultaneous jump
    applyStimulus(1, 0, 1, 32'h3A00, 1, 32'h3B00, 0, 0);
    checkOutput("eret_pc", pc, 32'h3A00);

    // wrap at top of address space
    applyStimulus(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    checkOutput("top_pc", pc, 32'hFFFF_FFFC);
    checkOutput("top_nseq", pc_next_seq, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("wrap_pc", pc, 32'h0);

    // jump wins over branch; misaligned target passes through
    applyStimulus(0, 0, 0, 0, 1, 32'h3200, 1, 32'h3300);
    checkOutput("jvb_pc", pc, 32'h3200);
    checkOutput("jvb_mis", {31'b0, pc_misalign}, 32'h0);
    applyStimulus(0, 0, 0, 0, 1, 32'h3202, 0, 0);
    checkOutput("mis_pc", pc, 32'h3202);
    checkOutput("mis_flag", {31'b0, pc_misalign}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("mis_seq", pc, 32'h3206);

    // asynchronous reset between edges discards pending redirect
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'h3700);
    checkOutput("prerst_rp", {31'b0, redirect_pending}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_pc", pc, 32'h3000);
    checkOutput("arst_rp", {31'b0, redirect_pending}, 32'h0);
    checkOutput("arst_fv", {31'b0, fetch_valid}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rerel_pc", pc, 32'h3004);
    checkOutput("rerel_fv", {31'b0, fetch_valid}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
